wb_uart_fifo: RTL and testbench
===============================

Name: wb_uart_fifo

Overview:
Wishbone slave that fronts a byte-stream UART core with parametrised RX and TX FIFOs, a status register and a maskable interrupt. It is the buffered successor to the single-byte Wishbone I/O controller. CPU writes are queued for the TX serializer, and received bytes are queued until the CPU reads them. The block sits between the MIPS Wishbone bus and the UART core; the serializer and deserializer live outside the block.

Parameters:
- BASE_ADDR, 32'h00000800, word-aligned base of the 4-word register window.
- FIFO_DEPTH, 16, entries per FIFO; must be a power of 2, range 2..128.
- DATA_W, 8, UART character width; range 5..8.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous active-low reset.
- dat_i  in  32  Wishbone write data.
- dat_o  out  32  Wishbone read data (registered).
- adr_i  in  32  Wishbone byte address.
- we_i  in  1  Wishbone write enable.
- sel_i  in  4  byte selects; a write takes effect only if sel_i[0]=1.
- cyc_i  in  1  Wishbone cycle.
- stb_i  in  1  Wishbone strobe.
- ack_o  out  1  Wishbone acknowledge.
- err_o  out  1  Wishbone error; see Optional Feature.
- tx_data_o  out  DATA_W  head of the TX FIFO.
- tx_valid_o  out  1  TX FIFO not empty.
- tx_ready_i  in  1  serializer accepts tx_data_o this cycle.
- rx_data_i  in  DATA_W  received character.
- rx_valid_i  in  1  one-cycle strobe: rx_data_i is valid.
- irq_o  out  1  level interrupt (registered).

Behaviour:
- Reset: asynchronous, active-low. Clock is clk_i only; no other clock domain.
- Reset values: dat_o=0, ack_o=0, err_o=0, irq_o=0, both FIFOs empty, sticky flags=0, IRQ_EN=0. tx_valid_o is therefore 0.
- Reset mid-transaction aborts it: no ack, and FIFO contents are lost.
- Register map (offsets from BASE_ADDR):
  - 0x0 DATA: write pushes dat_i[DATA_W-1:0] to the TX FIFO. Read pops the RX FIFO and returns the byte zero-extended.
  - 0x4 STATUS (read): bit0 rx_nonempty, bit1 rx_full, bit2 tx_empty, bit3 tx_full, bit4 rx_overrun (sticky), bit5 tx_overflow (sticky), [15:8] rx_count, [23:16] tx_count, remaining bits 0.
  - 0x4 STATUS (write): write-1-to-clear bits 4 and 5; other bits are ignored.
  - 0x8 IRQ_EN: R/W bits [2:0] = {overrun_en, tx_empty_en, rx_nonempty_en}.
  - 0xC: reserved; reads 0, writes ignored.
- Bus FSM, two states:
  - IDLE: on cyc_i&stb_i, perform the access, register dat_o, go to ACK.
  - ACK: ack_o=1 for exactly one cycle, then return to IDLE.
  - Read and write latency is therefore 1 cycle from the strobe to ack_o.
  - No request is sampled while in ACK.
  - Side effects (push or pop) occur exactly once per transaction.
- Unmapped addresses (outside BASE_ADDR..BASE_ADDR+0xC): ack_o, dat_o=0, no side effects.
- DATA write when the TX FIFO is full: the byte is dropped, tx_overflow is set, and the write is still acked.
- DATA read when the RX FIFO is empty: returns 0, no pop, still acked.
- RX push on rx_valid_i when the RX FIFO is full: the byte is dropped and rx_overrun is set.
  - If a CPU pop of the RX FIFO happens in the same cycle, the pop happens first and the push succeeds; no overrun is flagged.
- TX pop: occurs when tx_valid_o & tx_ready_i.
  - A simultaneous CPU push and TX pop are both honoured, including when the FIFO is full (tx_count unchanged, no overflow).
- Sticky flag conflict: if a set and a W1C clear hit the same flag in the same cycle, the set wins.
- FIFO pointers: log2(FIFO_DEPTH) bits wide, wrap modulo depth. Count is log2(FIFO_DEPTH)+1 bits, zero-extended into its 8-bit STATUS field.
- irq_o, registered: (rx_nonempty&en[0]) | (tx_empty&en[1]) | ((rx_overrun|tx_overflow)&en[2]). It updates one cycle after the condition changes.

Optional Feature:
- Macro: WB_UART_FIFO_ERR_EN.
- Defined: unmapped addresses and writes with sel_i[0]=0 to DATA terminate with err_o=1 instead of ack_o, using the same one-cycle timing, with no side effects.
- Undefined: err_o is tied to 0, and such accesses are acked as described in Behaviour.

Decomposition:
- Package wb_uart_pkg holds:
  - register offsets REG_DATA, REG_STATUS, REG_IRQ_EN;
  - STATUS bit indices;
  - IRQ_EN bit indices;
  - the bus state enum {ST_IDLE, ST_ACK}.
- One sub-module: sync_fifo (parameters WIDTH, DEPTH). It provides push, pop, dout, full, empty and count, and handles simultaneous push and pop at full and at empty. It is instantiated twice, once for RX and once for TX.

Test Plan:
1. After reset, read 0x804 -> dat_o=0x00000004 (only tx_empty set); irq_o=0; tx_valid_o=0.
2. Write 0x41,0x42 to 0x800 with tx_ready_i=0 -> tx_count=2, tx_data_o=0x41. Raise tx_ready_i for 2 cycles -> bytes 0x41 then 0x42 are emitted, tx_empty=1.
3. Pulse rx_valid_i 17 times with bytes 0x00..0x10, DEPTH=16 -> STATUS rx_full=1, rx_overrun=1, rx_count=16. Reading 0x800 returns 0x00. Write 0x10 to 0x804 -> rx_overrun=0.
4. RX FIFO full and a CPU DATA read pop coincides with rx_valid_i=1 (byte 0x55) -> no overrun, rx_count stays 16, and 0x55 is at the tail.
5. IRQ_EN=0x1 with an empty RX FIFO, then one rx_valid_i -> irq_o rises 1 cycle later. Reading DATA to empty -> irq_o falls 1 cycle after the pop.
6. Access to 0x900 -> ack_o (macro off) or err_o (macro on) after 1 cycle; dat_o=0; FIFOs untouched. Assert rst_ni low during ACK -> ack_o drops immediately.

Source files
------------

// File: rtl/wb_uart_pkg.sv
// Shared definitions for the buffered Wishbone UART front-end: register
// offsets, STATUS / IRQ_EN bit positions and the bus handshake state.
package wb_uart_pkg;

    // Byte offsets of the registers inside the 4-word window
    localparam logic [3:0] REG_DATA   = 4'h0;
    localparam logic [3:0] REG_STATUS = 4'h4;
    localparam logic [3:0] REG_IRQ_EN = 4'h8;

    // STATUS register bit positions
    localparam int unsigned ST_RX_NONEMPTY = 0;
    localparam int unsigned ST_RX_FULL     = 1;
    localparam int unsigned ST_TX_EMPTY    = 2;
    localparam int unsigned ST_TX_FULL     = 3;
    localparam int unsigned ST_RX_OVERRUN  = 4;
    localparam int unsigned ST_TX_OVERFLOW = 5;
    localparam int unsigned ST_RX_CNT_LSB  = 8;
    localparam int unsigned ST_TX_CNT_LSB  = 16;

    // IRQ_EN register bit positions
    localparam int unsigned IRQ_RX_NONEMPTY = 0;
    localparam int unsigned IRQ_TX_EMPTY    = 1;
    localparam int unsigned IRQ_OVERRUN     = 2;

    typedef enum logic {ST_IDLE, ST_ACK} bus_state_e;

endpackage

// File: rtl/wb_uart_fifo_sync_fifo.sv
// Single-clock FIFO with occupancy count. A pop frees its slot in the same
// cycle, so a push alongside a pop is accepted even when the FIFO is full;
// a pop on an empty FIFO is ignored, so push+pop at empty just pushes.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           din_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_en, pop_en;

    assign pop_en  = pop_i & (count_q != '0);
    assign push_en = push_i & ((count_q != FULL_CNT) | pop_en);

    assign dout_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // Storage array, written on accepted pushes only
    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointers wrap modulo DEPTH; count tracks occupancy
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_en)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push_en && !pop_en)      count_q <= count_q + (AW+1)'(1);
            else if (pop_en && !push_en) count_q <= count_q - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/wb_uart_fifo.sv
// Wishbone slave fronting a byte-stream UART with RX/TX FIFOs, a STATUS
// register with sticky error flags and a maskable level interrupt.
// Optional feature macro: WB_UART_FIFO_ERR_EN -- unmapped accesses and DATA
// writes without sel_i[0] terminate with err_o instead of ack_o.
module wb_uart_fifo
    import wb_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0800,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned DATA_W     = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [31:0]       dat_i,
    output logic [31:0]       dat_o,
    input  logic [31:0]       adr_i,
    input  logic              we_i,
    input  logic [3:0]        sel_i,
    input  logic              cyc_i,
    input  logic              stb_i,
    output logic              ack_o,
    output logic              err_o,
    output logic [DATA_W-1:0] tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    input  logic [DATA_W-1:0] rx_data_i,
    input  logic              rx_valid_i,
    output logic              irq_o
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    bus_state_e  state_q;
    logic        ack_q, err_q, irq_q;
    logic [31:0] dat_q;
    logic [2:0]  irq_en_q;
    logic        overrun_q, overflow_q;

    logic              req, hit, bad, err_c, wr_en;
    logic [3:0]        off;
    logic              tx_push, tx_pop, rx_pop, rx_pop_eff;
    logic              sts_wr, irqen_wr, overrun_set, overflow_set, irq_c;
    logic [31:0]       rdata;
    logic [DATA_W-1:0] rx_dout;
    logic              rx_full, rx_empty, tx_full, tx_empty;
    logic [CW-1:0]     rx_count, tx_count;
    logic              unused_bits;

    // Bytes received from the deserializer, drained by CPU DATA reads
    sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (rx_valid_i),
        .din_i   (rx_data_i),
        .pop_i   (rx_pop),
        .dout_o  (rx_dout),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .count_o (rx_count)
    );

    // Bytes written by the CPU, drained by the serializer
    sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (tx_push),
        .din_i   (dat_i[DATA_W-1:0]),
        .pop_i   (tx_pop),
        .dout_o  (tx_data_o),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .count_o (tx_count)
    );

    assign unused_bits = ^{adr_i[1:0], dat_i[31:DATA_W], sel_i[3:1]};

    // Address decode, side-effect strobes and read-data mux
    always_comb begin
        req          = cyc_i & stb_i & (state_q == ST_IDLE);
        hit          = (adr_i[31:4] == BASE_ADDR[31:4]);
        off          = {adr_i[3:2], 2'b00};
        wr_en        = we_i & sel_i[0];
        bad          = !hit || (we_i && (off == REG_DATA) && !sel_i[0]);
`ifdef WB_UART_FIFO_ERR_EN
        err_c        = bad;
`else
        err_c        = 1'b0;
`endif
        tx_push      = req & hit & (off == REG_DATA) & wr_en;
        rx_pop       = req & hit & (off == REG_DATA) & !we_i;
        rx_pop_eff   = rx_pop & !rx_empty;
        tx_pop       = !tx_empty & tx_ready_i;
        sts_wr       = req & hit & (off == REG_STATUS) & wr_en;
        irqen_wr     = req & hit & (off == REG_IRQ_EN) & wr_en;
        overrun_set  = rx_valid_i & rx_full & !rx_pop_eff;
        overflow_set = tx_push & tx_full & !tx_pop;
        irq_c        = (!rx_empty & irq_en_q[IRQ_RX_NONEMPTY])
                     | (tx_empty & irq_en_q[IRQ_TX_EMPTY])
                     | ((overrun_q | overflow_q) & irq_en_q[IRQ_OVERRUN]);
        rdata        = '0;
        if (hit && !we_i) begin
            case (off)
                REG_DATA:   if (!rx_empty) rdata = 32'(rx_dout);
                REG_STATUS: begin
                    rdata[ST_RX_NONEMPTY] = !rx_empty;
                    rdata[ST_RX_FULL]     = rx_full;
                    rdata[ST_TX_EMPTY]    = tx_empty;
                    rdata[ST_TX_FULL]     = tx_full;
                    rdata[ST_RX_OVERRUN]  = overrun_q;
                    rdata[ST_TX_OVERFLOW] = overflow_q;
                    rdata[ST_RX_CNT_LSB +: 8] = 8'(rx_count);
                    rdata[ST_TX_CNT_LSB +: 8] = 8'(tx_count);
                end
                REG_IRQ_EN: rdata = 32'(irq_en_q);
                default:    rdata = '0;
            endcase
        end
    end

    // Bus handshake FSM, registers, sticky flags (set beats clear) and irq
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            dat_q      <= '0;
            irq_en_q   <= '0;
            overrun_q  <= 1'b0;
            overflow_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            overrun_q  <= overrun_set | (overrun_q & !(sts_wr & dat_i[ST_RX_OVERRUN]));
            overflow_q <= overflow_set | (overflow_q & !(sts_wr & dat_i[ST_TX_OVERFLOW]));
            irq_q      <= irq_c;
            if (irqen_wr) irq_en_q <= dat_i[2:0];
            case (state_q)
                ST_IDLE: begin
                    if (cyc_i && stb_i) begin
                        state_q <= ST_ACK;
                        dat_q   <= rdata;
                        ack_q   <= !err_c;
                        err_q   <= err_c;
                    end
                end
                ST_ACK: begin
                    state_q <= ST_IDLE;
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign dat_o = dat_q;
    assign ack_o = ack_q;
    assign err_o = err_q;
    assign irq_o = irq_q;
    assign tx_valid_o = !tx_empty;

endmodule

// File: tb/tb_wb_uart_fifo.sv
// Directed self-checking bench for wb_uart_fifo (default parameters).
module tb_wb_uart_fifo;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] dat_i, dat_o, adr_i;
    logic        we_i, cyc_i, stb_i, ack_o, err_o;
    logic [3:0]  sel_i;
    logic [7:0]  tx_data_o, rx_data_i;
    logic        tx_valid_o, tx_ready_i, rx_valid_i, irq_o;

    int tests_run    = 0;
    int tests_failed = 0;

    wb_uart_fifo dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .dat_i(dat_i), .dat_o(dat_o),
        .adr_i(adr_i), .we_i(we_i), .sel_i(sel_i), .cyc_i(cyc_i),
        .stb_i(stb_i), .ack_o(ack_o), .err_o(err_o),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    // Bus cycle starting at a falling edge; bounded wait for ack/err
    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] r,
                           output logic ak, output logic er);
        bit done = 1'b0;
        r = '0; ak = 1'b0; er = 1'b0;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = w; adr_i = a; dat_i = d; sel_i = s;
        for (int i = 0; i < 4 && !done; i++) begin
            @(negedge clk_i);
            if (ack_o || err_o) begin
                done = 1'b1; r = dat_o; ak = ack_o; er = err_o;
            end
        end
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        tests_run++;
        if (!done) begin
            tests_failed++;
            $display("FAIL wb_timeout adr=%h: no termination within 4 cycles, required ack or err", a);
        end
    endtask

    task automatic wb_rd(input logic [31:0] a, output logic [31:0] r);
        logic ak, er;
        wb_xfer(1'b0, a, 32'h0, 4'hF, r, ak, er);
    endtask

    task automatic wb_wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r;
        logic ak, er;
        wb_xfer(1'b1, a, d, 4'hF, r, ak, er);
    endtask

    task automatic test_reset();
        logic [31:0] r;
        rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        tests_run++;
        if ({ack_o, err_o, irq_o, tx_valid_o} !== 4'b0 || dat_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs got ack=%b err=%b irq=%b txv=%b dat=%h, required all 0",
                     ack_o, err_o, irq_o, tx_valid_o, dat_o);
        end
        rst_ni = 1'b1;
        @(negedge clk_i);
        wb_rd(32'h804, r);
        tests_run++;
        if (r !== 32'h0000_0004) begin
            tests_failed++; $display("FAIL reset_status got %h, required 00000004", r);
        end
    endtask

    task automatic test_tx_basic();
        logic [31:0] r;
        wb_wr(32'h800, 32'h41);
        wb_wr(32'h800, 32'h42);
        wb_rd(32'h804, r);
        tests_run++;
        if (r !== 32'h0002_0000) begin
            tests_failed++; $display("FAIL tx_status2 got %h, required 00020000", r);
        end
        tests_run++;
        if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h41) begin
            tests_failed++; $display("FAIL tx_head got v=%b d=%h, required v=1 d=41", tx_valid_o, tx_data_o);
        end
        tx_ready_i = 1'b1;
        @(negedge clk_i);
        tests_run++;
        if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h42) begin
            tests_failed++; $display("FAIL tx_second got v=%b d=%h, required v=1 d=42", tx_valid_o, tx_data_o);
        end
        @(negedge clk_i);
        tx_ready_i = 1'b0;
        wb_rd(32'h804, r);
        tests_run++;
        if (tx_valid_o !== 1'b0 || r !== 32'h0000_0004) begin
            tests_failed++; $display("FAIL tx_drained got v=%b status=%h, required v=0 status=00000004", tx_valid_o, r);
        end
    endtask

    task automatic test_tx_overflow();
        logic [31:0] r;
        for (int i = 0; i < 16; i++) wb_wr(32'h800, 32'hA0 + i);
        wb_rd(32'h804, r);
        tests_run++;
        if (r !== 32'h0010_0008) begin
            tests_failed++; $display("FAIL tx_full_status got %h, required 00100008", r);
        end
        wb_wr(32'h800, 32'h5F);
        wb_rd(32'h804, r);
        tests_run++;
        if (r !== 32'h0010_0028) begin
            tests_failed++; $display("FAIL tx_overflow_status got %h, required 00100028", r);
        end
        wb_wr(32'h804, 32'h20);
        wb_rd(32'h804, r);
        tests_run++;
        if (r !== 32'h0010_0008) begin
            tests_failed++; $display("FAIL tx_overflow_w1c got %h, required 00100008", r);
        end
        // push and pop in the same cycle while full
        @(negedge clk_i);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 32'h800; dat_i = 32'hEE; sel_i = 4'hF;
        tx_ready_i = 1'b1;
        @(negedge clk_i);
        tx_ready_i = 1'b0;
        tests_run++;
        if (ack_o !== 1'b1) begin
            tests_failed++; $display("FAIL tx_pushpop_ack got %b, required 1", ack_o);
        end
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        wb_rd(32'h804, r);
        tests_run++;
        if (r !== 32'h0010_0008) begin
            tests_failed++; $display("FAIL tx_pushpop_status got %h, required 00100008", r);
        end
        tx_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] exp;
            exp = (i == 15) ? 8'hEE : 8'(8'hA1 + i);
            tests_run++;
            if (tx_valid_o !== 1'b1 || tx_data_o !== exp) begin
                tests_failed++;
                $display("FAIL tx_drain[%0d] got v=%b d=%h, required v=1 d=%h", i, tx_valid_o, tx_data_o, exp);
            end
            @(negedge clk_i);
        end
        tx_ready_i = 1'b0;
        tests_run++;
        if (tx_valid_o !== 1'b0) begin
            tests_failed++; $display("FAIL tx_drain_empty got v=%b, required 0", tx_valid_o);
        end
    endtask

    task automatic test_rx_overrun();
        logic [31:0] r;
        for (int i = 0; i < 17; i++) begin
            rx_data_i = 8'(i); rx_valid_i = 1'b1;
            @(negedge clk_i);
        end
        rx_valid_i = 1'b0;
        wb_rd(32'h804, r);
        tests_run++;
        if (r !== 32'h0000_1017) begin
            tests_failed++; $display("FAIL rx_full_status got %h, required 00001017", r);
        end
        wb_rd(32'h800, r);
        tests_run++;
        if (r !== 32'h0) begin
            tests_failed++; $display("FAIL rx_first_byte got %h, required 00000000", r);
        end
        wb_wr(32'h804, 32'h10);
        wb_rd(32'h804, r);
        tests_run++;
        if (r !== 32'h0000_0F05) begin
            tests_failed++; $display("FAIL rx_overrun_w1c got %h, required 00000F05", r);
        end
    endtask

    task automatic test_rx_pop_push_full();
        logic [31:0] r;
        logic [7:0]  exp;
        rx_data_i = 8'hAA; rx_valid_i = 1'b1;
        @(negedge clk_i);
        rx_valid_i = 1'b0;
        // CPU pop and deserializer push land on the same edge
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 32'h800; sel_i = 4'hF;
        rx_data_i = 8'h55; rx_valid_i = 1'b1;
        @(negedge clk_i);
        rx_valid_i = 1'b0;
        tests_run++;
        if (ack_o !== 1'b1 || dat_o !== 32'h01) begin
            tests_failed++; $display("FAIL rx_coincident_read got ack=%b dat=%h, required ack=1 dat=00000001", ack_o, dat_o);
        end
        cyc_i = 1'b0; stb_i = 1'b0;
        wb_rd(32'h804, r);
        tests_run++;
        if (r !== 32'h0000_1007) begin
            tests_failed++; $display("FAIL rx_coincident_status got %h, required 00001007", r);
        end
        for (int i = 0; i < 16; i++) begin
            exp = (i == 15) ? 8'h55 : (i == 14) ? 8'hAA : 8'(i + 2);
            wb_rd(32'h800, r);
            tests_run++;
            if (r !== 32'(exp)) begin
                tests_failed++; $display("FAIL rx_drain[%0d] got %h, required %h", i, r, exp);
            end
        end
        wb_rd(32'h804, r);
        tests_run++;
        if (r !== 32'h0000_0004) begin
            tests_failed++; $display("FAIL rx_drained_status got %h, required 00000004", r);
        end
    endtask

    task automatic test_irq();
        logic [31:0] r;
        wb_wr(32'h808, 32'h1);
        @(negedge clk_i);
        tests_run++;
        if (irq_o !== 1'b0) begin
            tests_failed++; $display("FAIL irq_idle got %b, required 0", irq_o);
        end
        rx_data_i = 8'h77; rx_valid_i = 1'b1;
        @(negedge clk_i);
        rx_valid_i = 1'b0;
        tests_run++;
        if (irq_o !== 1'b0) begin
            tests_failed++; $display("FAIL irq_same_cycle got %b, required 0", irq_o);
        end
        @(negedge clk_i);
        tests_run++;
        if (irq_o !== 1'b1) begin
            tests_failed++; $display("FAIL irq_rise got %b, required 1", irq_o);
        end
        wb_rd(32'h800, r);
        tests_run++;
        if (r !== 32'h77 || irq_o !== 1'b1) begin
            tests_failed++; $display("FAIL irq_pop got dat=%h irq=%b, required dat=00000077 irq=1", r, irq_o);
        end
        @(negedge clk_i);
        tests_run++;
        if (irq_o !== 1'b0) begin
            tests_failed++; $display("FAIL irq_fall got %b, required 0", irq_o);
        end
        wb_rd(32'h808, r);
        tests_run++;
        if (r !== 32'h1) begin
            tests_failed++; $display("FAIL irq_en_readback got %h, required 00000001", r);
        end
        wb_wr(32'h808, 32'h0);
    endtask

    task automatic test_unmapped_and_reset();
        logic [31:0] r;
        logic        ak, er;
        wb_xfer(1'b0, 32'h900, 32'h0, 4'hF, r, ak, er);
        tests_run++;
`ifdef WB_UART_FIFO_ERR_EN
        if (ak !== 1'b0 || er !== 1'b1 || r !== 32'h0) begin
            tests_failed++; $display("FAIL unmapped_read got ack=%b err=%b dat=%h, required ack=0 err=1 dat=0", ak, er, r);
        end
`else
        if (ak !== 1'b1 || er !== 1'b0 || r !== 32'h0) begin
            tests_failed++; $display("FAIL unmapped_read got ack=%b err=%b dat=%h, required ack=1 err=0 dat=0", ak, er, r);
        end
`endif
        wb_wr(32'h900, 32'h99);
        wb_xfer(1'b1, 32'h800, 32'h33, 4'hE, r, ak, er);
        tests_run++;
`ifdef WB_UART_FIFO_ERR_EN
        if (ak !== 1'b0 || er !== 1'b1) begin
            tests_failed++; $display("FAIL nosel_write got ack=%b err=%b, required ack=0 err=1", ak, er);
        end
`else
        if (ak !== 1'b1 || er !== 1'b0) begin
            tests_failed++; $display("FAIL nosel_write got ack=%b err=%b, required ack=1 err=0", ak, er);
        end
`endif
        wb_rd(32'h80C, r);
        tests_run++;
        if (r !== 32'h0) begin
            tests_failed++; $display("FAIL reserved_read got %h, required 00000000", r);
        end
        wb_rd(32'h804, r);
        tests_run++;
        if (r !== 32'h0000_0004 || tx_valid_o !== 1'b0) begin
            tests_failed++; $display("FAIL untouched_status got %h txv=%b, required 00000004 txv=0", r, tx_valid_o);
        end
        // reset while the ack is being presented
        wb_wr(32'h800, 32'h12);
        @(negedge clk_i);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 32'h804; sel_i = 4'hF;
        @(posedge clk_i);
        #1;
        tests_run++;
        if (ack_o !== 1'b1) begin
            tests_failed++; $display("FAIL ack_before_reset got %b, required 1", ack_o);
        end
        rst_ni = 1'b0;
        #1;
        tests_run++;
        if (ack_o !== 1'b0 || tx_valid_o !== 1'b0 || dat_o !== 32'h0) begin
            tests_failed++; $display("FAIL reset_abort got ack=%b txv=%b dat=%h, required 0 0 0", ack_o, tx_valid_o, dat_o);
        end
        cyc_i = 1'b0; stb_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        wb_rd(32'h804, r);
        tests_run++;
        if (r !== 32'h0000_0004) begin
            tests_failed++; $display("FAIL post_reset_status got %h, required 00000004", r);
        end
    endtask

    initial begin
        rst_ni = 1'b0; dat_i = '0; adr_i = '0; we_i = 1'b0; sel_i = 4'h0;
        cyc_i = 1'b0; stb_i = 1'b0; tx_ready_i = 1'b0; rx_data_i = '0; rx_valid_i = 1'b0;
        test_reset();
        test_tx_basic();
        test_tx_overflow();
        test_rx_overrun();
        test_rx_pop_push_full();
        test_irq();
        test_unmapped_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
